// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-map constants and controller FSM states.
// Device registers sit at xFE00..xFE06; everything else is RAM.
package lc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_sp_ram.sv
// Single-port RAM: synchronous write, combinational read of the addressed word.
// No reset; contents survive controller reset.
module lc3_sp_ram #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: one access in flight, ready pulse 2+WAIT_CYC (RAM) or 2 (device) cycles after req.
// req is ignored while busy; display output holds dd_data/dd_valid until dd_ready handshake.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 4096,
  parameter int WAIT_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic [7:0]        dd_data,
  output logic              dd_valid,
  input  logic              dd_ready
);

  localparam int RAM_AW = $clog2(MEM_DEPTH);

  function automatic logic is_dev(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(KBSR_ADDR)) || (a == ADDR_W'(KBDR_ADDR)) ||
           (a == ADDR_W'(DSR_ADDR))  || (a == ADDR_W'(DDR_ADDR));
  endfunction

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_access;

  logic [7:0]        r_kb_data;
  logic              r_kb_full, r_kb_ovr;
  logic [7:0]        r_dd_data;
  logic              r_dd_valid, r_dd_drop;

  logic              w_sel_kbsr, w_sel_kbdr, w_sel_dsr, w_sel_ddr, w_sel_ram;
  logic              w_kbsr_rd, w_kbdr_rd, w_dsr_rd, w_ddr_wr, w_dd_hs;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = is_dev(addr) ? 4'd0 : 4'(WAIT_CYC);
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && req) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  assign w_sel_kbsr = (r_addr == ADDR_W'(KBSR_ADDR));
  assign w_sel_kbdr = (r_addr == ADDR_W'(KBDR_ADDR));
  assign w_sel_dsr  = (r_addr == ADDR_W'(DSR_ADDR));
  assign w_sel_ddr  = (r_addr == ADDR_W'(DDR_ADDR));
  assign w_sel_ram  = ~is_dev(r_addr);

  assign w_kbsr_rd = w_access & ~r_we & w_sel_kbsr;
  assign w_kbdr_rd = w_access & ~r_we & w_sel_kbdr;
  assign w_dsr_rd  = w_access & ~r_we & w_sel_dsr;
  assign w_ddr_wr  = w_access &  r_we & w_sel_ddr;
  assign w_dd_hs   = r_dd_valid & dd_ready;
  // Reset gating keeps an aborted access from touching RAM.
  assign w_ram_we  = w_access & r_we & w_sel_ram & ~reset;

  lc3_sp_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (RAM_AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (r_addr[RAM_AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_rdata_nxt = '0;
    if (!r_we) begin
      if (w_sel_kbsr) begin
        w_rdata_nxt[15] = r_kb_full;
        w_rdata_nxt[14] = r_kb_ovr;
      end else if (w_sel_kbdr) begin
        w_rdata_nxt[7:0] = r_kb_data;
      end else if (w_sel_dsr) begin
        w_rdata_nxt[15] = ~r_dd_valid;
        w_rdata_nxt[14] = r_dd_drop;
      end else if (w_sel_ram) begin
        w_rdata_nxt = w_ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_rdata <= '0;
    else if (w_access) r_rdata <= w_rdata_nxt;
  end

  // A KBDR read frees the buffer in the same cycle, so a coincident strobe is kept, not dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kb_data <= 8'd0;
      r_kb_full <= 1'b0;
      r_kb_ovr  <= 1'b0;
    end else begin
      if (kb_valid && (!r_kb_full || w_kbdr_rd)) begin
        r_kb_data <= kb_data;
        r_kb_full <= 1'b1;
      end else if (w_kbdr_rd) begin
        r_kb_full <= 1'b0;
      end
      if (kb_valid && r_kb_full && !w_kbdr_rd) r_kb_ovr <= 1'b1;
      else if (w_kbsr_rd)                      r_kb_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dd_data  <= 8'd0;
      r_dd_valid <= 1'b0;
      r_dd_drop  <= 1'b0;
    end else begin
      if (w_ddr_wr && (!r_dd_valid || w_dd_hs)) begin
        r_dd_data  <= r_wdata[7:0];
        r_dd_valid <= 1'b1;
      end else if (w_dd_hs) begin
        r_dd_valid <= 1'b0;
      end
      if (w_ddr_wr && r_dd_valid && !w_dd_hs) r_dd_drop <= 1'b1;
      else if (w_dsr_rd)                      r_dd_drop <= 1'b0;
    end
  end

  assign rdata    = r_rdata;
  assign ready    = (r_state == S_RESP);
  assign busy     = (r_state != S_IDLE);
  assign dd_data  = r_dd_data;
  assign dd_valid = r_dd_valid;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: scoreboard of expected rdata/latency per access.
module tb_lc3_mem_ctrl;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [15:0] addr, wdata, rdata;
  logic        ready, busy;
  logic        kb_valid;
  logic [7:0]  kb_data, dd_data;
  logic        dd_valid, dd_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  bit          use_q[$];
  int          lat_q[$];

  lc3_mem_ctrl #(
    .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(4096), .WAIT_CYC(WC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy),
    .kb_valid(kb_valid), .kb_data(kb_data),
    .dd_data(dd_data), .dd_valid(dd_valid), .dd_ready(dd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  // One CPU access; optionally strobes kb_valid so it lands on the device access edge.
  task automatic access(input string tag, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit use_exp, input logic [15:0] exp,
                        input bit inj = 1'b0, input logic [7:0] ic = 8'h00);
    int n;
    bit got;
    logic [15:0] e;
    bit u;
    int l;
    exp_q.push_back(exp);
    use_q.push_back(use_exp);
    lat_q.push_back(is_dev(a) ? 2 : 2 + WC);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0; wdata = 16'h0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (inj && n == 1) begin kb_valid = 1'b1; kb_data = ic; end
      if (inj && n == 2) kb_valid = 1'b0;
      if (n == 1) chk({tag, "_busy"}, 16'(busy), 16'd1);
      if (ready) got = 1'b1;
    end
    e = exp_q.pop_front();
    u = use_q.pop_front();
    l = lat_q.pop_front();
    if (!got) begin
      chk({tag, "_ready_timeout"}, 16'(ready), 16'd1);
    end else begin
      chk({tag, "_latency"}, 16'(n), 16'(l));
      if (u) chk({tag, "_rdata"}, rdata, e);
    end
    @(negedge clk);
    chk({tag, "_ready_pulse"}, 16'(ready), 16'd0);
  endtask

  task automatic kb_send(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = c;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
    kb_valid = 1'b0; kb_data = 8'h0; dd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_dd_valid", 16'(dd_valid), 16'd0);
    chk("rst_dd_data", 16'(dd_data), 16'h0000);
    reset = 1'b0;

    // RAM write/read and address wrap-around
    access("wr3000", 1'b1, 16'h3000, 16'h1234, 1'b1, 16'h0000);
    access("rd3000", 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h1234);
    access("wr4000", 1'b1, 16'h4000, 16'hBEEF, 1'b1, 16'h0000);
    access("rd0000_wrap", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF);
    access("wrFE01", 1'b1, 16'hFE01, 16'h7777, 1'b1, 16'h0000);
    access("rd0E01_wrap", 1'b0, 16'h0E01, 16'h0000, 1'b1, 16'h7777);

    // Keyboard: second character overruns
    kb_send(8'h41);
    kb_send(8'h42);
    access("kbsr_ovr", 1'b0, 16'hFE00, 16'h0, 1'b1, 16'hC000);
    access("kbdr_41", 1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0041);
    access("kbsr_clr", 1'b0, 16'hFE00, 16'h0, 1'b1, 16'h0000);

    // Display: second write is dropped while the first is pending
    access("ddr_48", 1'b1, 16'hFE06, 16'h0048, 1'b0, 16'h0);
    chk("dd_valid_48", 16'(dd_valid), 16'd1);
    access("ddr_49", 1'b1, 16'hFE06, 16'h0049, 1'b0, 16'h0);
    chk("dd_data_keep", 16'(dd_data), 16'h0048);
    chk("dd_valid_keep", 16'(dd_valid), 16'd1);
    access("dsr_drop", 1'b0, 16'hFE04, 16'h0, 1'b1, 16'h4000);
    @(negedge clk);
    dd_ready = 1'b1;
    @(negedge clk);
    dd_ready = 1'b0;
    chk("dd_valid_drain", 16'(dd_valid), 16'd0);
    access("dsr_idle", 1'b0, 16'hFE04, 16'h0, 1'b1, 16'h8000);
    access("ddr_rd", 1'b0, 16'hFE06, 16'h0, 1'b1, 16'h0000);
    access("ddr_50", 1'b1, 16'hFE06, 16'h0050, 1'b0, 16'h0);
    chk("dd_data_50", 16'(dd_data), 16'h0050);

    // Reset during WAIT aborts the RAM write and the ready pulse
    access("wr3001_old", 1'b1, 16'h3001, 16'h1111, 1'b1, 16'h0000);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h3001; wdata = 16'h5555;
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0; wdata = 16'h0;
    @(negedge clk);
    chk("abort_busy", 16'(busy), 16'd1);
    reset = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 16'(ready), 16'd0);
      if (i == 3) reset = 1'b0;
    end
    chk("abort_idle", 16'(busy), 16'd0);
    chk("abort_dd_valid", 16'(dd_valid), 16'd0);
    access("rd3001_old", 1'b0, 16'h3001, 16'h0, 1'b1, 16'h1111);

    // KBDR read coinciding with a new character while full
    kb_send(8'h33);
    access("kbdr_same", 1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0033, 1'b1, 8'h5A);
    access("kbsr_full", 1'b0, 16'hFE00, 16'h0, 1'b1, 16'h8000);
    access("kbdr_5A", 1'b0, 16'hFE02, 16'h0, 1'b1, 16'h005A);
    access("kbsr_empty", 1'b0, 16'hFE00, 16'h0, 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
